// File: rtl/clk_enable_gen.sv
// Fractional-accumulator clock-enable generator: T, M and per-channel power-of-two enables with speed switching and halt.
// Optional legacy half-rate toggle output on clk_toggle_o when CLK_ENABLE_GEN_TOGGLE_OUT_EN is defined.
`timescale 1ns/1ps
module clk_enable_gen #(
  parameter int              ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC    = 180143985,
  parameter int              CNT_W   = 16,
  parameter int              NUM_CH  = 4,
  parameter int              SHIFT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      halt_i,
  input  logic                      speed_req_i,
  input  logic                      cnt_clr_i,
  input  logic [NUM_CH*SHIFT_W-1:0] ch_shift_i,
  output logic                      t_tick_o,
  output logic                      m_tick_o,
  output logic [NUM_CH-1:0]         ch_tick_o,
  output logic [CNT_W-1:0]          t_count_o,
  output logic                      speed_o,
  output logic                      speed_ack_o
`ifdef CLK_ENABLE_GEN_TOGGLE_OUT_EN
  ,
  output logic                      clk_toggle_o
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   inc_sel;
  logic [ACC_W-1:0]   acc_sum;
  logic               carry;
  logic               t_evt, m_evt, switch_now;
  logic [1:0]         m_phase_reg;
  logic [CNT_W-1:0]   t_count_reg;
  logic               t_tick_reg, m_tick_reg, speed_reg, speed_ack_reg;
  logic [NUM_CH-1:0]  ch_tick_reg;
  logic [NUM_CH-1:0]  ch_hit;

  assign inc_sel          = speed_reg ? {INC[ACC_W-2:0], 1'b0} : INC;
  assign {carry, acc_sum} = {1'b0, acc_reg} + {1'b0, inc_sel};
  assign t_evt            = !halt_i && carry;
  assign m_evt            = t_evt && (m_phase_reg == 2'd3);

  // A channel hits when the low s bits of the count before this tick are all ones.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      logic [SHIFT_W-1:0] s_raw;
      logic [31:0]        s_eff;
      logic [CNT_W-1:0]   mask;
      assign s_raw      = ch_shift_i[gi*SHIFT_W +: SHIFT_W];
      assign s_eff      = (int'(s_raw) >= CNT_W) ? 32'(CNT_W) : 32'(s_raw);
      assign mask       = ~({CNT_W{1'b1}} << s_eff);
      assign ch_hit[gi] = ((t_count_reg & mask) == mask);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    switch_now = 1'b0;
    case (state_reg)
      IDLE: if (speed_req_i) state_next = PEND;
      PEND: if (m_evt) begin
        state_next = IDLE;
        switch_now = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      m_phase_reg   <= '0;
      t_count_reg   <= '0;
      t_tick_reg    <= 1'b0;
      m_tick_reg    <= 1'b0;
      ch_tick_reg   <= '0;
      speed_reg     <= 1'b0;
      speed_ack_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      t_tick_reg    <= t_evt;
      m_tick_reg    <= m_evt;
      speed_ack_reg <= switch_now;
      // A coincident count clear suppresses every channel enable.
      ch_tick_reg   <= (t_evt && !cnt_clr_i) ? ch_hit : '0;
      if (switch_now) speed_reg <= ~speed_reg;
      if (!halt_i) acc_reg <= acc_sum;
      if (t_evt) m_phase_reg <= m_phase_reg + 2'd1;
      if (cnt_clr_i) t_count_reg <= '0;
      else if (t_evt) t_count_reg <= t_count_reg + 1'b1;
    end
  end

  assign t_tick_o    = t_tick_reg;
  assign m_tick_o    = m_tick_reg;
  assign ch_tick_o   = ch_tick_reg;
  assign t_count_o   = t_count_reg;
  assign speed_o     = speed_reg;
  assign speed_ack_o = speed_ack_reg;

`ifdef CLK_ENABLE_GEN_TOGGLE_OUT_EN
  logic toggle_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_reg <= 1'b0;
    else if (t_evt) toggle_reg <= ~toggle_reg;
  end

  assign clk_toggle_o = toggle_reg;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: cycle model of tick/count/speed rules plus directed literal checks and a long-run rate check.
`timescale 1ns/1ps
module tb_clk_enable_gen;

  localparam longint TWO32 = 64'd1 << 32;
  localparam longint INC_V = 64'd1 << 30;
  localparam longint INC_D = 64'd180143985;
  localparam int     RATE_N = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0, speed_req = 1'b0, cnt_clr = 1'b0;
  logic [15:0] ch_shift = {4'd15, 4'd3, 4'd0, 4'd2};
  logic        t_tick, m_tick, speed, speed_ack;
  logic [3:0]  ch_tick;
  logic [7:0]  t_count;

  logic        rst_r = 1'b1;
  logic        t_r, m_r, speed_r, ack_r;
  logic [3:0]  ch_r;
  logic [15:0] cnt_r;
  logic [15:0] zero_shift = '0;
`ifdef CLK_ENABLE_GEN_TOGGLE_OUT_EN
  logic        clk_toggle, tog_r;
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(.ACC_W(32), .INC(32'h4000_0000), .CNT_W(8), .NUM_CH(4), .SHIFT_W(4)) dut (
    .clk(clk), .rst(rst), .halt_i(halt), .speed_req_i(speed_req), .cnt_clr_i(cnt_clr),
    .ch_shift_i(ch_shift), .t_tick_o(t_tick), .m_tick_o(m_tick), .ch_tick_o(ch_tick),
    .t_count_o(t_count), .speed_o(speed), .speed_ack_o(speed_ack)
`ifdef CLK_ENABLE_GEN_TOGGLE_OUT_EN
    , .clk_toggle_o(clk_toggle)
`endif
  );

  clk_enable_gen dut_r (
    .clk(clk), .rst(rst_r), .halt_i(1'b0), .speed_req_i(1'b0), .cnt_clr_i(1'b0),
    .ch_shift_i(zero_shift), .t_tick_o(t_r), .m_tick_o(m_r), .ch_tick_o(ch_r),
    .t_count_o(cnt_r), .speed_o(speed_r), .speed_ack_o(ack_r)
`ifdef CLK_ENABLE_GEN_TOGGLE_OUT_EN
    , .clk_toggle_o(tog_r)
`endif
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: carries of a 32-bit phase sum, m_tick on every 4th tick since reset.
  longint m_acc, m_sum;
  int     m_ticks, m_cnt;
  bit     m_speed, m_pend, pend_start;
  logic   e_t, e_m, e_ack, e_tog;
  logic [3:0] e_ch;
  int     tcnt_obs = 0, mcnt_obs = 0, ack_obs = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_acc = 0; m_ticks = 0; m_cnt = 0; m_speed = 0; m_pend = 0;
      e_t = 0; e_m = 0; e_ack = 0; e_ch = '0; e_tog = 0;
    end else begin
      pend_start = m_pend;
      e_t = 0; e_m = 0; e_ack = 0; e_ch = '0;
      if (!halt) begin
        m_sum = m_acc + (m_speed ? 2 * INC_V : INC_V);
        m_acc = m_sum % TWO32;
        if (m_sum >= TWO32) begin
          e_t = 1;
          e_m = (m_ticks % 4 == 3);
          m_ticks++;
          for (int k = 0; k < 4; k++) begin
            int s;
            s = int'(ch_shift[k*4 +: 4]);
            if (s > 8) s = 8;
            e_ch[k] = !cnt_clr && ((m_cnt % (1 << s)) == (1 << s) - 1);
          end
          m_cnt = (m_cnt + 1) % 256;
          if (m_pend && e_m) begin
            m_speed = !m_speed; m_pend = 0; e_ack = 1;
          end
        end
      end
      if (cnt_clr) m_cnt = 0;
      if (!pend_start && speed_req) m_pend = 1;
      e_tog = e_tog ^ e_t;
    end
    #1;
    chk("t_tick", t_tick, e_t);
    chk("m_tick", m_tick, e_m);
    chk("ch_tick", ch_tick, e_ch);
    chk("t_count", t_count, m_cnt);
    chk("speed", speed, m_speed);
    chk("speed_ack", speed_ack, e_ack);
`ifdef CLK_ENABLE_GEN_TOGGLE_OUT_EN
    chk("clk_toggle", clk_toggle, e_tog);
`endif
    tcnt_obs += int'(t_tick);
    mcnt_obs += int'(m_tick);
    ack_obs  += int'(speed_ack);
  end

  // Long-run rate with the default increment.
  int  r_t = 0, r_m = 0;
  bit  rate_done = 0;
  initial begin
    repeat (2) @(negedge clk);
    rst_r = 1'b0;
    repeat (RATE_N) begin
      @(posedge clk); #1;
      r_t += int'(t_r);
      r_m += int'(m_r);
    end
    rate_done = 1;
  end

  task automatic window(input int n, input string nm, input int exp_t, input int exp_m);
    int t0, m0;
    t0 = tcnt_obs; m0 = mcnt_obs;
    repeat (n) @(negedge clk);
    chk({nm, "_t_ticks"}, tcnt_obs - t0, exp_t);
    chk({nm, "_m_ticks"}, mcnt_obs - m0, exp_m);
  endtask

  task automatic pulse_req();
    @(negedge clk) speed_req = 1'b1;
    @(negedge clk) speed_req = 1'b0;
  endtask

  task automatic wait_ack(input string nm, input int a0);
    int g = 0;
    while (ack_obs == a0 && g < 100) begin @(negedge clk); g++; end
    chk(nm, ack_obs - a0, 1);
  endtask

  initial begin
    int g, a0, save_cnt;
    repeat (2) @(negedge clk);
    chk("rst_t_tick", t_tick, 0);
    chk("rst_t_count", t_count, 0);
    chk("rst_speed", speed, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("first_tick_early", t_tick, 0);
    @(posedge clk);
    #1 chk("first_tick", t_tick, 1);
    chk("first_count", t_count, 1);

    window(64, "single", 16, 4);

    g = 0;
    while (m_ticks % 4 != 1 && g < 100) begin @(negedge clk); g++; end
    chk("reach_phase1", m_ticks % 4, 1);
    a0 = ack_obs;
    pulse_req();
    pulse_req();
    wait_ack("ack_to_double", a0);
    chk("speed_double", speed, 1);
    a0 = ack_obs;
    window(64, "double", 32, 8);
    chk("no_queued_req", ack_obs - a0, 0);

    a0 = ack_obs;
    pulse_req();
    wait_ack("ack_to_single", a0);
    chk("speed_single", speed, 0);
    window(32, "single_again", 8, 2);

    g = 0;
    while (m_cnt != 255 && g < 2000) begin @(negedge clk); g++; end
    chk("reach_ff", m_cnt, 255);
    g = 0;
    do begin @(posedge clk); #1; g++; end while (!t_tick && g < 20);
    chk("wrap_count", t_count, 0);
    chk("wrap_ch_all", ch_tick, 4'hF);

    g = 0;
    while (!(m_cnt == 7 && m_acc + (m_speed ? 2 * INC_V : INC_V) >= TWO32) && g < 2000) begin
      @(negedge clk); g++;
    end
    chk("reach_cnt7", m_cnt, 7);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 chk("clr_t_tick", t_tick, 1);
    chk("clr_count", t_count, 0);
    chk("clr_ch", ch_tick, 0);
    @(negedge clk) cnt_clr = 1'b0;

    halt = 1'b1;
    save_cnt = m_cnt;
    a0 = ack_obs;
    begin
      int t0;
      t0 = tcnt_obs;
      repeat (10) @(negedge clk);
      speed_req = 1'b1;
      @(negedge clk) speed_req = 1'b0;
      repeat (39) @(negedge clk);
      chk("halt_ticks", tcnt_obs - t0, 0);
    end
    chk("halt_count", t_count, save_cnt);
    chk("halt_speed_held", speed, 0);
    chk("halt_no_ack", ack_obs - a0, 0);
    halt = 1'b0;
    wait_ack("ack_after_halt", a0);
    chk("speed_after_halt", speed, 1);

    pulse_req();
    rst = 1'b1;
    #1;
    chk("rst_mid_t", t_tick, 0);
    chk("rst_mid_m", m_tick, 0);
    chk("rst_mid_ch", ch_tick, 0);
    chk("rst_mid_count", t_count, 0);
    chk("rst_mid_speed", speed, 0);
    chk("rst_mid_ack", speed_ack, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a0 = ack_obs;
    window(80, "post_rst", 20, 5);
    chk("post_rst_no_ack", ack_obs - a0, 0);
    chk("post_rst_speed", speed, 0);

    g = 0;
    while (!rate_done && g < 50000) begin @(negedge clk); g++; end
    chk("rate_done", rate_done, 1);
    chk("rate_t_model", r_t, (longint'(RATE_N) * INC_D) >> 32);
    chk("rate_t_literal", r_t, 1677);
    chk("rate_m_literal", r_m, 419);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
